button_event_classifier: RTL and testbench

Multi-channel successor to the single long-press counter. Each of NUM_BUTTONS raw button inputs is synchronised and debounced, then classified by a per-channel FSM into single-cycle event pulses: short press, long press, double press and auto-repeat while held. It sits between the board push-buttons and the control logic, replacing per-button counters and edge detectors.

---
 rtl/button_event_classifier.sv | 211 +++++++++++++++++++++
 tb/tb_button_event_classifier.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_classifier.sv
// Multi-channel push-button classifier. Each raw button is synchronised,
// debounced and fed to its own FSM. The FSM turns the debounced level into
// single-cycle short, long, double and auto-repeat events.
//
// Ports:
//   clk           system clock
//   resetn        asynchronous active-low reset
//   clear         synchronous abort of every channel FSM (debounce untouched)
//   btn           raw active-high button levels, asynchronous to clk
//   short_pulse   1-cycle short-press event per channel
//   long_pulse    1-cycle long-press event per channel
//   double_pulse  1-cycle double-press event per channel
//   repeat_pulse  1-cycle auto-repeat event per channel
//   held          high while the channel is in LONG
module button_event_classifier #(
    parameter int unsigned NUM_BUTTONS   = 4,
    parameter int unsigned CLK_PERIOD_ns = 20,
    parameter int unsigned DEBOUNCE_ns   = 10000000,
    parameter int unsigned LONG_PRESS_ns = 1000000000,
    parameter int unsigned DOUBLE_GAP_ns = 300000000,
    parameter int unsigned REPEAT_ns     = 200000000,
    parameter bit          DOUBLE_EN     = 1'b1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   clear,
    input  logic [NUM_BUTTONS-1:0] btn,
    output logic [NUM_BUTTONS-1:0] short_pulse,
    output logic [NUM_BUTTONS-1:0] long_pulse,
    output logic [NUM_BUTTONS-1:0] double_pulse,
    output logic [NUM_BUTTONS-1:0] repeat_pulse,
    output logic [NUM_BUTTONS-1:0] held
);

    localparam int unsigned DEB_CYC  = DEBOUNCE_ns / CLK_PERIOD_ns;
    localparam int unsigned LONG_CYC = LONG_PRESS_ns / CLK_PERIOD_ns;
    localparam int unsigned GAP_CYC  = DOUBLE_GAP_ns / CLK_PERIOD_ns;
    localparam int unsigned REP_CYC  = REPEAT_ns / CLK_PERIOD_ns;
    localparam int unsigned DEB_W    = $clog2(DEB_CYC + 1);
    localparam int unsigned T_MAX_LG = (LONG_CYC > GAP_CYC) ? LONG_CYC : GAP_CYC;
    localparam int unsigned T_MAX    = (T_MAX_LG > REP_CYC) ? T_MAX_LG : REP_CYC;
    localparam int unsigned T_W      = $clog2(T_MAX + 1);

    // Reject parameter sets whose cycle counts truncate to zero.
    if (DEB_CYC < 1 || LONG_CYC < 1 || GAP_CYC < 1 || REP_CYC < 1) begin : g_bad_timing
        $error("button_event_classifier: every timing parameter must be at least one clock period");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_GAP,
        S_LONG,
        S_CONSUME
    } state_e;

    logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
    logic [NUM_BUTTONS-1:0] deb_q, deb_d;
    logic [DEB_W-1:0]       deb_cnt_q [NUM_BUTTONS];
    logic [DEB_W-1:0]       deb_cnt_d [NUM_BUTTONS];
    state_e                 state_q   [NUM_BUTTONS];
    state_e                 state_d   [NUM_BUTTONS];
    logic [T_W-1:0]         t_q       [NUM_BUTTONS];
    logic [T_W-1:0]         t_d       [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] short_q, short_d;
    logic [NUM_BUTTONS-1:0] long_q, long_d;
    logic [NUM_BUTTONS-1:0] double_q, double_d;
    logic [NUM_BUTTONS-1:0] repeat_q, repeat_d;
    logic [NUM_BUTTONS-1:0] held_q, held_d;

    // Saturating timer increment.
    function automatic logic [T_W-1:0] sat_inc(input logic [T_W-1:0] v);
        return (v == T_W'(T_MAX)) ? v : v + T_W'(1);
    endfunction

    // Debounce: count while the synchronised level disagrees with deb,
    // toggle deb when the disagreement has lasted DEB_CYC cycles.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_W'(DEB_CYC - 1)) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
                end
            end
        end
    end

    // Per-channel event FSM; clear overrides every state rule.
    always_comb begin
        short_d  = '0;
        long_d   = '0;
        double_d = '0;
        repeat_d = '0;
        held_d   = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            state_d[i] = state_q[i];
            t_d[i]     = t_q[i];
            if (clear) begin
                state_d[i] = deb_q[i] ? S_CONSUME : S_IDLE;
                t_d[i]     = '0;
            end else begin
                case (state_q[i])
                    S_IDLE: begin
                        if (deb_q[i]) begin
                            state_d[i] = S_PRESS;
                            t_d[i]     = '0;
                        end
                    end
                    S_PRESS: begin
                        if (!deb_q[i]) begin
                            t_d[i] = '0;
                            if (DOUBLE_EN) begin
                                state_d[i] = S_GAP;
                            end else begin
                                state_d[i] = S_IDLE;
                                short_d[i] = 1'b1;
                            end
                        end else if (t_q[i] == T_W'(LONG_CYC - 1)) begin
                            state_d[i] = S_LONG;
                            t_d[i]     = '0;
                            long_d[i]  = 1'b1;
                        end else begin
                            t_d[i] = sat_inc(t_q[i]);
                        end
                    end
                    S_GAP: begin
                        // A re-press on the expiry cycle still wins as a double.
                        if (deb_q[i]) begin
                            state_d[i]  = S_CONSUME;
                            t_d[i]      = '0;
                            double_d[i] = 1'b1;
                        end else if (t_q[i] == T_W'(GAP_CYC - 1)) begin
                            state_d[i] = S_IDLE;
                            t_d[i]     = '0;
                            short_d[i] = 1'b1;
                        end else begin
                            t_d[i] = sat_inc(t_q[i]);
                        end
                    end
                    S_LONG: begin
                        // Release takes priority over a coincident repeat.
                        if (!deb_q[i]) begin
                            state_d[i] = S_IDLE;
                            t_d[i]     = '0;
                        end else if (t_q[i] == T_W'(REP_CYC - 1)) begin
                            t_d[i]      = '0;
                            repeat_d[i] = 1'b1;
                        end else begin
                            t_d[i] = sat_inc(t_q[i]);
                        end
                    end
                    S_CONSUME: begin
                        if (!deb_q[i]) begin
                            state_d[i] = S_IDLE;
                            t_d[i]     = '0;
                        end
                    end
                    default: begin
                        state_d[i] = S_IDLE;
                        t_d[i]     = '0;
                    end
                endcase
            end
            held_d[i] = (state_d[i] == S_LONG);
        end
    end

    // State, timers and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            short_q  <= '0;
            long_q   <= '0;
            double_q <= '0;
            repeat_q <= '0;
            held_q   <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                deb_cnt_q[i] <= '0;
                state_q[i]   <= S_IDLE;
                t_q[i]       <= '0;
            end
        end else begin
            sync1_q  <= btn;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            repeat_q <= repeat_d;
            held_q   <= held_d;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
                state_q[i]   <= state_d[i];
                t_q[i]       <= t_d[i];
            end
        end
    end

    assign short_pulse  = short_q;
    assign long_pulse   = long_q;
    assign double_pulse = double_q;
    assign repeat_pulse = repeat_q;
    assign held         = held_q;

endmodule

// File: tb/tb_button_event_classifier.sv
// Directed bench for button_event_classifier. Two instances share clk,
// resetn and clear: dut_a with double-press detection, dut_b without.
// Expected pulses are queued with their absolute cycle when stimulus is
// driven; a negedge monitor pops and compares all eight pulse vectors.
module tb_button_event_classifier;

    typedef struct {
        int         cyc;
        int         kind;
        logic [3:0] mask;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       clear;
    logic [3:0] btn, btn_b;
    logic [3:0] short_a, long_a, double_a, repeat_a, held_a;
    logic [3:0] short_b, long_b, double_b, repeat_b, held_b;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    string kname [8] = '{"short_a", "long_a", "double_a", "repeat_a",
                         "short_b", "long_b", "double_b", "repeat_b"};

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    button_event_classifier #(
        .NUM_BUTTONS(4), .CLK_PERIOD_ns(20), .DEBOUNCE_ns(100),
        .LONG_PRESS_ns(400), .DOUBLE_GAP_ns(200), .REPEAT_ns(100), .DOUBLE_EN(1'b1)
    ) dut_a (
        .clk(clk), .resetn(resetn), .clear(clear), .btn(btn),
        .short_pulse(short_a), .long_pulse(long_a), .double_pulse(double_a),
        .repeat_pulse(repeat_a), .held(held_a)
    );

    button_event_classifier #(
        .NUM_BUTTONS(4), .CLK_PERIOD_ns(20), .DEBOUNCE_ns(100),
        .LONG_PRESS_ns(400), .DOUBLE_GAP_ns(200), .REPEAT_ns(100), .DOUBLE_EN(1'b0)
    ) dut_b (
        .clk(clk), .resetn(resetn), .clear(clear), .btn(btn_b),
        .short_pulse(short_b), .long_pulse(long_b), .double_pulse(double_b),
        .repeat_pulse(repeat_b), .held(held_b)
    );

    // Every cycle: all pulse vectors must match what the queue expects now.
    always @(negedge clk) begin
        logic [3:0] exp_v [8];
        logic [3:0] obs_v [8];
        obs_v[0] = short_a;  obs_v[1] = long_a;  obs_v[2] = double_a;  obs_v[3] = repeat_a;
        obs_v[4] = short_b;  obs_v[5] = long_b;  obs_v[6] = double_b;  obs_v[7] = repeat_b;
        for (int k = 0; k < 8; k++) exp_v[k] = 4'b0000;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                exp_v[sb[i].kind] = exp_v[sb[i].kind] | sb[i].mask;
                sb.delete(i);
            end
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            assert (obs_v[k] === exp_v[k]) else begin
                errors++;
                $error("FAIL %s cyc=%0d observed=%b expected=%b", kname[k], cyc, obs_v[k], exp_v[k]);
            end
        end
    end

    task automatic goto_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_ev(input int c, input int k, input logic [3:0] m);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.mask = m;
        sb.push_back(e);
    endtask

    task automatic check_vec(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
        end
    endtask

    initial begin
        int w;
        int f;
        btn    = 4'b0000;
        btn_b  = 4'b0000;
        clear  = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_vec("reset_held_a", held_a, 4'b0000);
        check_vec("reset_held_b", held_b, 4'b0000);
        check_vec("reset_short_a", short_a, 4'b0000);
        check_vec("reset_long_a", long_a, 4'b0000);
        resetn = 1'b1;
        goto_cyc(cyc + 10);

        // Short press, both double modes.
        w = cyc;
        btn[0] = 1'b1;  btn_b[0] = 1'b1;
        push_ev(w + 30, 0, 4'b0001);
        push_ev(w + 20, 4, 4'b0001);
        goto_cyc(w + 12);
        btn[0] = 1'b0;  btn_b[0] = 1'b0;
        goto_cyc(w + 60);

        // Long press with auto-repeat; release on a repeat cycle.
        w = cyc;
        btn[1] = 1'b1;
        push_ev(w + 28, 1, 4'b0010);
        for (int k = 0; k < 7; k++) push_ev(w + 33 + 5 * k, 3, 4'b0010);
        goto_cyc(w + 27);
        check_vec("held_before_long", held_a, 4'b0000);
        goto_cyc(w + 28);
        check_vec("held_at_long", held_a, 4'b0010);
        goto_cyc(w + 60);
        btn[1] = 1'b0;
        goto_cyc(w + 67);
        check_vec("held_last", held_a, 4'b0010);
        goto_cyc(w + 68);
        check_vec("held_dropped", held_a, 4'b0000);
        goto_cyc(w + 100);

        // Double press; second press held well past the long threshold.
        w = cyc;
        btn[2] = 1'b1;
        push_ev(w + 24, 2, 4'b0100);
        goto_cyc(w + 10);
        btn[2] = 1'b0;
        goto_cyc(w + 16);
        btn[2] = 1'b1;
        goto_cyc(w + 60);
        check_vec("held_consume", held_a, 4'b0000);
        goto_cyc(w + 66);
        btn[2] = 1'b0;
        goto_cyc(w + 100);

        // Bounce rejection and a glitch one cycle short of the debounce time.
        for (int k = 0; k < 5; k++) begin
            btn[3] = 1'b1;
            goto_cyc(cyc + 3);
            btn[3] = 1'b0;
            goto_cyc(cyc + 3);
        end
        goto_cyc(cyc + 20);
        btn[3] = 1'b1;
        goto_cyc(cyc + 4);
        btn[3] = 1'b0;
        goto_cyc(cyc + 30);

        // Re-press landing exactly on the last gap cycle -> double.
        w = cyc;
        btn[0] = 1'b1;
        goto_cyc(w + 10);
        btn[0] = 1'b0;
        f = w + 10;
        goto_cyc(f + 10);
        btn[0] = 1'b1;
        push_ev(f + 18, 2, 4'b0001);
        goto_cyc(f + 18);
        btn[0] = 1'b0;
        goto_cyc(f + 50);

        // Re-press one cycle later -> short, then a fresh press -> short.
        w = cyc;
        btn[0] = 1'b1;
        goto_cyc(w + 10);
        btn[0] = 1'b0;
        f = w + 10;
        goto_cyc(f + 11);
        btn[0] = 1'b1;
        push_ev(f + 18, 0, 4'b0001);
        goto_cyc(f + 19);
        btn[0] = 1'b0;
        push_ev(f + 37, 0, 4'b0001);
        goto_cyc(f + 70);

        // clear during LONG: held drops, no repeats, nothing on release.
        w = cyc;
        btn[1] = 1'b1;
        push_ev(w + 28, 1, 4'b0010);
        goto_cyc(w + 30);
        check_vec("held_pre_clear", held_a, 4'b0010);
        clear = 1'b1;
        goto_cyc(w + 31);
        clear = 1'b0;
        check_vec("held_post_clear", held_a, 4'b0000);
        goto_cyc(w + 40);
        check_vec("held_after_clear", held_a, 4'b0000);
        goto_cyc(w + 50);
        btn[1] = 1'b0;
        goto_cyc(w + 90);

        // resetn mid-PRESS on ch0 while ch1 is in LONG.
        w = cyc;
        btn[1] = 1'b1;
        goto_cyc(w + 20);
        btn[0] = 1'b1;
        push_ev(w + 28, 1, 4'b0010);
        goto_cyc(w + 30);
        check_vec("held_pre_reset", held_a, 4'b0010);
        resetn = 1'b0;
        #1;
        check_vec("held_in_reset", held_a, 4'b0000);
        goto_cyc(w + 31);
        btn = 4'b0000;
        goto_cyc(w + 33);
        resetn = 1'b1;
        goto_cyc(w + 100);

        // All channels together -> identical simultaneous shorts.
        w = cyc;
        btn = 4'b1111;
        goto_cyc(w + 12);
        btn = 4'b0000;
        push_ev(w + 30, 0, 4'b1111);
        goto_cyc(w + 60);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
